cmd_sequencer: RTL and testbench

CMD_SEQUENCER -- requirements
Module: cmd_sequencer

---
 rtl/bp_seq_pkg.sv | 43 ++++
 rtl/cmd_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_cmd_sequencer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_seq_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : bp_seq_pkg
//  Description : Shared definitions for the command sequencer: command word
//                field positions, opcode values, counter widths and the
//                sequencer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package bp_seq_pkg;

    // Command word layout: [15:12] opcode, [11:0] argument
    localparam int c_cmd_width = 16;
    localparam int c_op_msb    = 15;
    localparam int c_op_lsb    = 12;
    localparam int c_arg_msb   = 11;
    localparam int c_arg_lsb   = 0;
    localparam int c_op_width  = c_op_msb - c_op_lsb + 1;
    localparam int c_arg_width = c_arg_msb - c_arg_lsb + 1;

    // READ_N remaining-transfer counter width
    localparam int c_cnt_width = 8;

    // Opcodes; anything above c_op_read_n is illegal
    localparam logic [c_op_width-1:0] c_op_nop     = 4'd0;
    localparam logic [c_op_width-1:0] c_op_cs_set  = 4'd1;
    localparam logic [c_op_width-1:0] c_op_aux_set = 4'd2;
    localparam logic [c_op_width-1:0] c_op_write   = 4'd3;
    localparam logic [c_op_width-1:0] c_op_xfer    = 4'd4;
    localparam logic [c_op_width-1:0] c_op_delay   = 4'd5;
    localparam logic [c_op_width-1:0] c_op_read_n  = 4'd6;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_SPI_START = 3'd2,
        ST_SPI_WAIT  = 3'd3,
        ST_PUSH      = 3'd4,
        ST_DELAY     = 3'd5
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/cmd_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cmd_sequencer
//  Description : Fetches command words from a first-word-fall-through FIFO,
//                drives CS/AUX pins, runs byte transfers on an external SPI
//                master, inserts delays and pushes received bytes into a
//                result FIFO.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clock, reset        : system clock, synchronous active-high reset
//    enable              : allows fetching of the next command
//    in_fifo_nempty/data : command FIFO status and head word (FWFT)
//    in_fifo_pop         : consumes the head command word
//    out_fifo_full       : result FIFO cannot accept a word
//    out_fifo_shift/data : writes one result word
//    spi_start/spi_tx    : starts a byte transfer / byte to send
//    spi_busy/done/rx    : SPI master status and received byte
//    cs_out, aux_out     : pin levels
//    busy                : sequencer is not idle
//    error, error_clr    : sticky illegal-opcode flag and its clear
// ============================================================================
module cmd_sequencer
    import bp_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int SPI_WIDTH  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  in_fifo_nempty,
    input  logic [DATA_WIDTH-1:0] in_fifo_data,
    output logic                  in_fifo_pop,
    input  logic                  out_fifo_full,
    output logic                  out_fifo_shift,
    output logic [DATA_WIDTH-1:0] out_fifo_data,
    output logic                  spi_start,
    output logic [SPI_WIDTH-1:0]  spi_tx,
    input  logic                  spi_busy,
    input  logic                  spi_done,
    input  logic [SPI_WIDTH-1:0]  spi_rx,
    output logic                  cs_out,
    output logic                  aux_out,
    output logic                  busy,
    output logic                  error,
    input  logic                  error_clr
);

    seq_state_t              r_state;
    logic [DATA_WIDTH-1:0]   r_cmd;
    logic [c_arg_width-1:0]  r_delay;
    logic [c_cnt_width-1:0]  r_remain;
    logic                    r_armed;

    logic [c_op_width-1:0]   w_op;
    logic [c_arg_width-1:0]  w_arg;
    logic                    w_fetch;

    assign w_op  = r_cmd[c_op_msb:c_op_lsb];
    assign w_arg = r_cmd[c_arg_msb:c_arg_lsb];

    // r_armed stays low for the first cycle after reset so that no pop can
    // be issued in that cycle even if the FIFO already holds a word. The pop
    // is decoded from IDLE directly so that it coincides with the cycle in
    // which the head word is latched.
    assign w_fetch     = (r_state == ST_IDLE) && r_armed && enable && in_fifo_nempty && !reset;
    assign in_fifo_pop = w_fetch;

    // The shift is qualified with the live full flag so a word is never
    // written into a full FIFO; out_fifo_data is already held from capture.
    assign out_fifo_shift = (r_state == ST_PUSH) && !out_fifo_full && !reset;

    assign busy = (r_state != ST_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cmd         <= '0;
            r_delay       <= '0;
            r_remain      <= '0;
            r_armed       <= 1'b0;
            cs_out        <= 1'b1;
            aux_out       <= 1'b0;
            error         <= 1'b0;
            spi_start     <= 1'b0;
            spi_tx        <= '0;
            out_fifo_data <= '0;
        end else begin
            r_armed   <= 1'b1;
            spi_start <= 1'b0;

            // A clear wins over an illegal opcode decoded in the same cycle
            if (error_clr) begin
                error <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_fetch) begin
                        r_cmd   <= in_fifo_data;
                        r_state <= ST_DECODE;
                    end
                end

                ST_DECODE: begin
                    case (w_op)
                        c_op_nop: begin
                            r_state <= ST_IDLE;
                        end
                        c_op_cs_set: begin
                            cs_out  <= w_arg[0];
                            r_state <= ST_IDLE;
                        end
                        c_op_aux_set: begin
                            aux_out <= w_arg[0];
                            r_state <= ST_IDLE;
                        end
                        c_op_write, c_op_xfer: begin
                            r_state <= ST_SPI_START;
                        end
                        c_op_read_n: begin
                            r_remain <= w_arg[c_cnt_width-1:0];
                            r_state  <= ST_SPI_START;
                        end
                        c_op_delay: begin
                            if (w_arg == '0) begin
                                r_state <= ST_IDLE;
                            end else begin
                                r_delay <= w_arg;
                                r_state <= ST_DELAY;
                            end
                        end
                        default: begin
                            if (!error_clr) begin
                                error <= 1'b1;
                            end
                            r_state <= ST_IDLE;
                        end
                    endcase
                end

                ST_DELAY: begin
                    // Leaving on the count of one gives exactly arg cycles here
                    if (r_delay == 12'd1) begin
                        r_delay <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_delay <= r_delay - 12'd1;
                    end
                end

                ST_SPI_START: begin
                    if (!spi_busy) begin
                        spi_start <= 1'b1;
                        spi_tx    <= (w_op == c_op_read_n) ? {SPI_WIDTH{1'b1}}
                                                           : w_arg[SPI_WIDTH-1:0];
                        r_state   <= ST_SPI_WAIT;
                    end
                end

                ST_SPI_WAIT: begin
                    if (spi_done) begin
                        if (w_op == c_op_write) begin
                            r_state <= ST_IDLE;
                        end else begin
                            out_fifo_data <= DATA_WIDTH'(spi_rx);
                            r_state       <= ST_PUSH;
                        end
                    end
                end

                ST_PUSH: begin
                    if (!out_fifo_full) begin
                        // r_remain counts transfers still owed after this one
                        if ((w_op == c_op_read_n) && (r_remain != '0)) begin
                            r_remain <= r_remain - 8'd1;
                            r_state  <= ST_SPI_START;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cmd_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_cmd_sequencer
//  Description : Self-checking bench for cmd_sequencer with FIFO and SPI
//                models and a command-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cmd_sequencer;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        in_fifo_nempty;
    logic [15:0] in_fifo_data;
    logic        in_fifo_pop;
    logic        out_fifo_full;
    logic        out_fifo_shift;
    logic [15:0] out_fifo_data;
    logic        spi_start;
    logic [7:0]  spi_tx;
    logic        spi_busy;
    logic        spi_done;
    logic [7:0]  spi_rx;
    logic        cs_out;
    logic        aux_out;
    logic        busy;
    logic        error;
    logic        error_clr;

    cmd_sequencer #(.DATA_WIDTH(16), .SPI_WIDTH(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .in_fifo_nempty (in_fifo_nempty),
        .in_fifo_data   (in_fifo_data),
        .in_fifo_pop    (in_fifo_pop),
        .out_fifo_full  (out_fifo_full),
        .out_fifo_shift (out_fifo_shift),
        .out_fifo_data  (out_fifo_data),
        .spi_start      (spi_start),
        .spi_tx         (spi_tx),
        .spi_busy       (spi_busy),
        .spi_done       (spi_done),
        .spi_rx         (spi_rx),
        .cs_out         (cs_out),
        .aux_out        (aux_out),
        .busy           (busy),
        .error          (error),
        .error_clr      (error_clr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int cyc;
        bit is_aux;
        bit val;
    } pin_exp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;

    logic [15:0] cmd_q[$];
    logic [15:0] sc_cmds[$];
    logic [15:0] popped_q[$];
    int          pop_cyc_q[$];
    logic [7:0]  tx_obs[$];
    logic [7:0]  rx_log[$];
    logic [15:0] push_obs[$];
    logic [7:0]  exp_tx[$];
    logic [15:0] exp_push[$];
    pin_exp_t    pin_q[$];

    bit m_cs = 1'b1, m_aux = 1'b0, m_err = 1'b0, m_clr_held = 1'b0;

    bit         en_force = 1'b1, rand_en = 1'b0, full_force = 1'b0, rand_full = 1'b0;
    int         lat_min = 1, lat_max = 4;
    bit         rx_forced = 1'b0;
    logic [7:0] rx_force_val = 8'h00;
    int         busy_cnt = 0;
    logic [7:0] cur_tx = 8'h00;
    bit         pend_pop = 1'b0, pend_start = 1'b0;
    int         aux_change_cyc = -1;
    logic       aux_prev = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rx_at(input int k);
        if (k < rx_log.size()) return rx_log[k];
        return 8'hxx;
    endfunction

    // ---------------- environment: command FIFO, result FIFO, SPI slave ----
    initial begin
        enable = 1'b1; in_fifo_nempty = 1'b0; in_fifo_data = 16'h0000;
        out_fifo_full = 1'b0; spi_busy = 1'b0; spi_done = 1'b0; spi_rx = 8'h00;
        forever begin
            @(posedge clock); #1;
            cyc++;
            if (reset) begin
                spi_busy = 1'b0; spi_done = 1'b0; busy_cnt = 0;
            end else begin
                if (pend_pop && cmd_q.size() != 0) void'(cmd_q.pop_front());
                spi_done = 1'b0;
                if (pend_start) begin
                    busy_cnt = $urandom_range(lat_max, lat_min);
                    spi_busy = 1'b1;
                end else if (spi_busy) begin
                    busy_cnt--;
                    if (busy_cnt <= 0) begin
                        spi_busy = 1'b0;
                        spi_done = 1'b1;
                        spi_rx   = rx_forced ? rx_force_val : 8'($urandom);
                        rx_log.push_back(spi_rx);
                    end
                end
            end
            pend_pop = 1'b0; pend_start = 1'b0;
            in_fifo_nempty = (cmd_q.size() != 0);
            in_fifo_data   = in_fifo_nempty ? cmd_q[0] : 16'hDEAD;
            enable         = rand_en ? ($urandom_range(2, 0) != 0) : en_force;
            out_fifo_full  = full_force || (rand_full && ($urandom_range(3, 0) == 0));

            @(negedge clock);
            if (!reset) begin
                if (in_fifo_pop) begin
                    check_eq("pop_in_idle", busy, 0);
                    check_eq("pop_nonempty", in_fifo_nempty, 1);
                    pend_pop = 1'b1;
                    popped_q.push_back(in_fifo_data);
                    pop_cyc_q.push_back(cyc);
                    if (in_fifo_data[15:12] == 4'd1 || in_fifo_data[15:12] == 4'd2) begin
                        pin_exp_t p;
                        p.cyc = cyc + 2;
                        p.is_aux = (in_fifo_data[15:12] == 4'd2);
                        p.val = in_fifo_data[0];
                        pin_q.push_back(p);
                    end
                end
                if (spi_start) begin
                    check_eq("start_while_busy", spi_busy, 0);
                    pend_start = 1'b1;
                    cur_tx = spi_tx;
                    tx_obs.push_back(spi_tx);
                end
                if (spi_busy) check_eq("tx_stable", spi_tx, cur_tx);
                if (out_fifo_shift) begin
                    check_eq("shift_while_full", out_fifo_full, 0);
                    push_obs.push_back(out_fifo_data);
                end
                while (pin_q.size() != 0 && pin_q[0].cyc <= cyc) begin
                    if (pin_q[0].cyc == cyc) begin
                        if (pin_q[0].is_aux) check_eq("aux_timing", aux_out, pin_q[0].val);
                        else                 check_eq("cs_timing", cs_out, pin_q[0].val);
                    end
                    void'(pin_q.pop_front());
                end
                if (aux_out !== aux_prev) aux_change_cyc = cyc;
                aux_prev = aux_out;
            end else begin
                pin_q.delete();
                aux_prev = aux_out;
            end
        end
    end

    // ---------------- helpers ----------------------------------------------
    task automatic issue(input logic [15:0] c);
        cmd_q.push_back(c);
        sc_cmds.push_back(c);
    endtask

    task automatic wait_done(input int budget);
        int idle_cnt = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock); #1;
            if (cmd_q.size() == 0 && !busy && !spi_busy && !spi_done) idle_cnt++;
            else idle_cnt = 0;
            if (idle_cnt >= 3) return;
        end
        check_eq("wait_done_timeout", idle_cnt, 3);
    endtask

    // which: 0 = transfers started, 1 = transfers completed
    task automatic wait_cnt(input int which, input int n, input int budget);
        int got = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock); #1;
            got = (which == 0) ? tx_obs.size() : rx_log.size();
            if (got >= n) return;
        end
        check_eq("wait_cnt_timeout", got, n);
    endtask

    task automatic clear_logs();
        sc_cmds.delete(); popped_q.delete(); pop_cyc_q.delete();
        tx_obs.delete(); rx_log.delete(); push_obs.delete();
    endtask

    // Command-level reference: what each issued command must produce
    task automatic end_scenario(input string tag);
        int k = 0;
        int bad_tx = 0;
        int bad_push = 0;
        logic [3:0]  op;
        logic [11:0] arg;
        exp_tx.delete(); exp_push.delete();
        foreach (sc_cmds[i]) begin
            op  = sc_cmds[i][15:12];
            arg = sc_cmds[i][11:0];
            case (op)
                4'd0, 4'd5: ;
                4'd1: m_cs  = arg[0];
                4'd2: m_aux = arg[0];
                4'd3: begin exp_tx.push_back(arg[7:0]); k++; end
                4'd4: begin
                    exp_tx.push_back(arg[7:0]);
                    exp_push.push_back({8'h00, rx_at(k)});
                    k++;
                end
                4'd6: begin
                    for (int j = 0; j <= int'(arg[7:0]); j++) begin
                        exp_tx.push_back(8'hFF);
                        exp_push.push_back({8'h00, rx_at(k)});
                        k++;
                    end
                end
                default: if (!m_clr_held) m_err = 1'b1;
            endcase
        end
        check_eq({tag, "_pops"}, popped_q.size(), sc_cmds.size());
        check_eq({tag, "_ntx"}, tx_obs.size(), exp_tx.size());
        check_eq({tag, "_npush"}, push_obs.size(), exp_push.size());
        foreach (exp_tx[i])   if (i >= tx_obs.size()   || tx_obs[i]   !== exp_tx[i])   bad_tx++;
        foreach (exp_push[i]) if (i >= push_obs.size() || push_obs[i] !== exp_push[i]) bad_push++;
        check_eq({tag, "_tx_data_errs"}, bad_tx, 0);
        check_eq({tag, "_push_data_errs"}, bad_push, 0);
        check_eq({tag, "_cs"}, cs_out, m_cs);
        check_eq({tag, "_aux"}, aux_out, m_aux);
        check_eq({tag, "_err"}, error, m_err);
        clear_logs();
    endtask

    function automatic logic [15:0] rand_cmd();
        case ($urandom_range(9, 0))
            0: return {4'd0, 12'($urandom)};
            1: return {4'd1, 12'($urandom)};
            2: return {4'd2, 12'($urandom)};
            3: return {4'd3, 12'($urandom)};
            4, 5: return {4'd4, 12'($urandom)};
            6: return {4'd5, 12'($urandom_range(6, 0))};
            7: return {4'd6, 4'($urandom), 8'($urandom_range(4, 0))};
            8: return {4'($urandom_range(15, 7)), 12'($urandom)};
            default: return 16'h5000;
        endcase
    endfunction

    // ---------------- test sequence ----------------------------------------
    initial begin
        reset = 1'b1;
        error_clr = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_cs", cs_out, 1);
        check_eq("rst_aux", aux_out, 0);
        check_eq("rst_err", error, 0);
        check_eq("rst_start", spi_start, 0);
        check_eq("rst_pop", in_fifo_pop, 0);
        check_eq("rst_shift", out_fifo_shift, 0);
        check_eq("rst_tx", spi_tx, 0);
        check_eq("rst_data", out_fifo_data, 0);
        @(posedge clock); #2;
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // CS toggles with pin timing checked per pop
        issue(16'h1000);
        issue(16'h1001);
        wait_done(200);
        end_scenario("cs");

        // XFER with a fixed returned byte
        rx_forced = 1'b1; rx_force_val = 8'h3C;
        issue(16'h40A5);
        wait_done(200);
        check_eq("xfer_tx", (tx_obs.size() == 1) ? {24'h0, tx_obs[0]} : 32'hFFFF_FFFF, 32'hA5);
        check_eq("xfer_data", (push_obs.size() == 1) ? {16'h0, push_obs[0]} : 32'hFFFF_FFFF, 32'h003C);
        end_scenario("xfer");
        rx_forced = 1'b0;

        // READ_N 2 with the result FIFO full across the second push
        issue(16'h6002);
        wait_cnt(0, 2, 200);
        full_force = 1'b1;
        wait_cnt(1, 2, 200);
        repeat (5) @(negedge clock);
        #1;
        check_eq("stall_push_cnt", push_obs.size(), 1);
        full_force = 1'b0;
        wait_done(200);
        end_scenario("readn_stall");

        // DELAY timing, then zero-length DELAY
        issue(16'h500A);
        issue(16'h2001);
        wait_done(200);
        check_eq("delay10_latency", (pop_cyc_q.size() > 0) ? aux_change_cyc - pop_cyc_q[0] : -1, 14);
        end_scenario("delay10");
        issue(16'h5000);
        issue(16'h2000);
        wait_done(200);
        check_eq("delay0_latency", (pop_cyc_q.size() > 0) ? aux_change_cyc - pop_cyc_q[0] : -1, 4);
        end_scenario("delay0");

        // Illegal opcode, clear, then normal command
        issue(16'hF000);
        wait_done(200);
        check_eq("err_set", error, 1);
        end_scenario("illegal");
        @(posedge clock); #2; error_clr = 1'b1;
        @(posedge clock); #2; error_clr = 1'b0;
        @(negedge clock); #1;
        check_eq("err_clr", error, 0);
        m_err = 1'b0;
        issue(16'h4011);
        wait_done(200);
        end_scenario("after_err");

        // Clear held while an illegal opcode decodes
        @(posedge clock); #2; error_clr = 1'b1;
        m_clr_held = 1'b1;
        issue(16'h7123);
        wait_done(200);
        end_scenario("clr_prio");
        @(posedge clock); #2; error_clr = 1'b0;
        m_clr_held = 1'b0;

        // READ_N with the maximum count
        issue(16'h60FF);
        wait_done(5000);
        check_eq("readn_ff_pushes", push_obs.size(), 256);
        end_scenario("readn_ff");

        // Reset while an XFER waits for the SPI master
        lat_min = 3;
        issue(16'h1000);
        issue(16'h4055);
        wait_cnt(0, 1, 200);
        @(posedge clock); #2; reset = 1'b1;
        @(posedge clock); #2; reset = 1'b0;
        @(negedge clock); #1;
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_cs", cs_out, 1);
        check_eq("mid_rst_shift", out_fifo_shift, 0);
        check_eq("mid_rst_start", spi_start, 0);
        check_eq("mid_rst_pop", in_fifo_pop, 0);
        repeat (6) @(negedge clock);
        #1;
        check_eq("mid_rst_no_push", push_obs.size(), 0);
        clear_logs();
        m_cs = 1'b1; m_aux = 1'b0; m_err = 1'b0;
        lat_min = 1;
        issue(16'h4066);
        wait_done(200);
        end_scenario("post_rst");

        // Random command streams with random enable and back-pressure
        rand_en = 1'b1;
        rand_full = 1'b1;
        for (int b = 0; b < 3; b++) begin
            for (int n = 0; n < 25; n++) issue(rand_cmd());
            wait_done(4000);
            end_scenario("rand");
        end
        rand_en = 1'b0;
        rand_full = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "time limit reached");
    end

endmodule
`default_nettype wire
